dmac_ahb_slave_mem: RTL and testbench
=====================================

// Module: dmac_ahb_slave_mem
// PURPOSE
//  AHB-Lite word-addressed memory slave answering the DMAC master port (MAddress/MWData/MWrite/MTrans).
//  Serves single and burst (NONSEQ/SEQ) transfers with pipelined address/data phases.
//  Inserts a configurable number of wait states per beat and returns a two-cycle ERROR on bad addresses.
//  Acts as source/destination memory for DMAC system-level benches and SoC integration.
// PARAMETERS
//  DEPTH_WORDS   256           number of 32-bit words; power of two, >=4
//  WAIT_STATES   0             HReadyOut low cycles per accepted beat (0..15)
//  BASE_ADDR     32'h0000_0000 byte address of word 0; aligned to DEPTH_WORDS*4
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  HSel       in   1   slave select from decoder
//  HAddr      in   32  byte address (address phase)
//  HTrans     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  HWrite     in   1   1 = write, 0 = read (address phase)
//  HWData     in   32  write data (data phase)
//  HReadyIn   in   1   bus-level HREADY (previous transfer complete)
//  HRData     out  32  read data (data phase)
//  HReadyOut  out  1   1 = current data phase completes this cycle
//  HResp      out  2   00 OKAY, 01 ERROR
// BEHAVIOUR
//  - Reset: HReadyOut=1, HResp=00, HRData=0, FSM=IDLE, wait counter=0, pending write dropped; memory array NOT reset.
//  - Accept: HSel & HTrans[1] & HReadyIn at a rising edge; latch addr, write, index=(HAddr-BASE_ADDR)>>2.
//  - IDLE/BUSY or HSel=0 with HReadyIn=1: no accept; next cycle zero-wait OKAY, no memory effect.
//  - Bad address: HAddr[1:0]!=0 or HAddr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS-1].
//  - FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//    IDLE: HReadyOut=1, HResp=00. Accept good & WAIT_STATES>0 -> WAIT (counter=WAIT_STATES-1);
//          accept good & WAIT_STATES=0 -> DATA; accept bad -> ERR1; else stay.
//    WAIT: HReadyOut=0, HResp=00; counter decrements; at 0 -> DATA. New address phases ignored (HReadyIn low).
//    DATA: HReadyOut=1, HResp=00; write beat commits mem[idx]<=HWData at this edge; read beat drives
//          HRData=mem[idx]. Same-edge accept handled as from IDLE (pipelined bursts back-to-back).
//    ERR1: HReadyOut=0, HResp=01; -> ERR2 unconditionally. No memory write.
//    ERR2: HReadyOut=1, HResp=01; accept handled as from IDLE (master normally drives IDLE here).
//  - Latency: zero-wait beat = 1 data-phase cycle; each beat costs 1+WAIT_STATES cycles; error = 2 cycles.
//  - HRData driven only in read DATA cycles; holds last value otherwise (not X, not cleared).
//  - Read-after-write hazard: read accepted in the same cycle its preceding write commits to the same
//    index returns the new HWData (bypass), never the stale word.
//  - Index arithmetic: 32-bit subtract, then $clog2(DEPTH_WORDS) bits after >>2; no wrap-around aliasing,
//    out-of-range is always ERROR.
//  - HWrite/HAddr/HWData of a non-accepted cycle never alter state or memory.
//  - Reset asserted mid-WAIT/DATA/ERR: FSM to IDLE immediately; in-flight write not committed.
// TESTING
//  - WAIT_STATES=0: NONSEQ write 0x0000_0010 data 0xDEADBEEF, then read 0x10 -> HReadyOut stays 1, HRData=0xDEADBEEF, HResp=00.
//  - INCR4 write 0x20..0x2C data 1,2,3,4 then INCR4 read -> 8 consecutive OKAY beats, reads return 1,2,3,4.
//  - WAIT_STATES=2: single read 0x40 -> HReadyOut low exactly 2 cycles, high on 3rd with mem[16].
//  - Write 0x50=0xA5A5_A5A5 immediately followed by read 0x50 -> read returns 0xA5A5A5A5 (bypass).
//  - Access 0x0000_0400 (DEPTH_WORDS=256) and 0x0000_0002 -> HResp=01 with HReadyOut 0 then 1; memory unchanged.
//  - rst pulsed during WAIT of write 0x60=0x1234 -> HReadyOut=1, HResp=00 at once; later read 0x60 != 0x1234 unless pre-written.

Source files
------------

// File: rtl/dmac_ahb_slave_mem_if.sv
// AHB-Lite slave-side bus bundle between the DMAC master port and the memory slave.
interface dmac_ahb_slave_mem_if;
  logic        HSel;
  logic [31:0] HAddr;
  logic [1:0]  HTrans;
  logic        HWrite;
  logic [31:0] HWData;
  logic        HReadyIn;
  logic [31:0] HRData;
  logic        HReadyOut;
  logic [1:0]  HResp;

  modport master (
    output HSel, HAddr, HTrans, HWrite, HWData, HReadyIn,
    input  HRData, HReadyOut, HResp
  );

  modport slave (
    input  HSel, HAddr, HTrans, HWrite, HWData, HReadyIn,
    output HRData, HReadyOut, HResp
  );
endinterface

// File: rtl/dmac_ahb_slave_mem.sv
// AHB-Lite word-addressed memory slave with per-beat wait states, two-cycle
// ERROR on bad addresses and read-after-write bypass for back-to-back beats.
module dmac_ahb_slave_mem #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  dmac_ahb_slave_mem_if.slave  bus
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [CW-1:0] WS_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            write_q, write_d;
  logic            ready_q, ready_d;
  logic [1:0]      resp_q, resp_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [31:0]     off;
  logic            addr_bad;
  logic [IW-1:0]   new_idx;
  logic            accept;
  logic            commit;

  // Address decode: offset from base, alignment/range check, word index.
  always_comb begin
    off      = bus.HAddr - BASE_ADDR;
    addr_bad = (bus.HAddr[1:0] != 2'b00) || (off >= SPAN);
    new_idx  = off[IW+1:2];
    accept   = bus.HSel & bus.HTrans[1] & bus.HReadyIn;
    commit   = (state_q == S_DATA) && write_q;
  end

  // Next-state, beat tracking and registered response/read data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    rdata_d = rdata_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          if (!write_q) rdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all sample a new address phase the same way.
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = new_idx;
          write_d = bus.HWrite;
          if (addr_bad) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_DATA;
            // A write committing this edge to the same word wins over the array.
            if (!bus.HWrite)
              rdata_d = (commit && (idx_q == new_idx)) ? bus.HWData : mem[new_idx];
          end
        end
      end
    endcase
    ready_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    resp_d  = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      ready_q <= 1'b1;
      resp_q  <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array; contents survive reset, writes land at the end of the data phase.
  always_ff @(posedge clk) begin
    if (commit) mem[idx_q] <= bus.HWData;
  end

  assign bus.HRData    = rdata_q;
  assign bus.HReadyOut = ready_q;
  assign bus.HResp     = resp_q;

endmodule

// File: tb/tb_dmac_ahb_slave_mem.sv
// Bench for dmac_ahb_slave_mem: a zero-wait and a two-wait instance driven by a
// pipelined AHB master, checked against a flat word-array memory model.
module tb_dmac_ahb_slave_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmac_ahb_slave_mem_if b0();
  dmac_ahb_slave_mem_if b2();
  assign b0.HReadyIn = b0.HReadyOut;
  assign b2.HReadyIn = b2.HReadyOut;

  dmac_ahb_slave_mem #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0));
  dmac_ahb_slave_mem #(.DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut2 (
    .clk(clk), .rst(rst), .bus(b2));

  typedef struct { bit write; logic [31:0] addr; logic [31:0] wdata; } item_t;
  item_t q[$];

  logic [31:0] mdl [2][256];
  bit          kn  [2][256];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input int sel, input logic hs, input logic [1:0] tr,
                     input logic wr, input logic [31:0] ad);
    if (sel == 0) begin b0.HSel = hs; b0.HTrans = tr; b0.HWrite = wr; b0.HAddr = ad; end
    else          begin b2.HSel = hs; b2.HTrans = tr; b2.HWrite = wr; b2.HAddr = ad; end
  endtask

  task automatic drv_wd(input int sel, input logic [31:0] d);
    if (sel == 0) b0.HWData = d; else b2.HWData = d;
  endtask

  task automatic smp(input int sel, output logic rdy, output logic [1:0] rsp, output logic [31:0] rd);
    if (sel == 0) begin rdy = b0.HReadyOut; rsp = b0.HResp; rd = b0.HRData; end
    else          begin rdy = b2.HReadyOut; rsp = b2.HResp; rd = b2.HRData; end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h400);
  endfunction

  // Runs q as one pipelined burst; entered and left at posedge+1.
  task automatic run_burst(input int sel);
    int a = 0;
    int d = -1;
    int waits = 0;
    int guard = 0;
    int n = q.size();
    int ws = (sel == 0) ? 0 : 2;
    logic rdy;
    logic [1:0] rsp;
    logic [31:0] rd;
    bit bad;
    int wi;
    while ((a < n || d >= 0) && guard < 400) begin
      guard++;
      if (a < n) drv(sel, 1'b1, (a == 0) ? 2'b10 : 2'b11, q[a].write, q[a].addr);
      else       drv(sel, 1'b0, 2'b00, 1'b0, 32'h0);
      drv_wd(sel, (d >= 0 && q[d].write) ? q[d].wdata : $urandom);
      @(negedge clk);
      smp(sel, rdy, rsp, rd);
      if (d >= 0) begin
        bad = is_bad(q[d].addr);
        if (!rdy) begin
          waits++;
          if (bad) chk("err1_resp", 32'(rsp), 32'h1);
        end else begin
          chk("wait_cycles", 32'(waits), bad ? 32'd1 : 32'(ws));
          chk("beat_resp", 32'(rsp), bad ? 32'h1 : 32'h0);
          if (!bad) begin
            wi = int'(q[d].addr[9:2]);
            if (q[d].write) begin mdl[sel][wi] = q[d].wdata; kn[sel][wi] = 1'b1; end
            else if (kn[sel][wi]) chk("read_data", rd, mdl[sel][wi]);
          end
          waits = 0;
        end
      end else begin
        chk("idle_ready", 32'(rdy), 32'h1);
        chk("idle_resp", 32'(rsp), 32'h0);
      end
      if (rdy) begin
        d = (a < n) ? a : -1;
        if (a < n) a++;
      end
      @(posedge clk); #1;
    end
    chk("burst_done", 32'(a < n || d >= 0), 32'h0);
    q.delete();
  endtask

  function automatic item_t mk(input bit w, input logic [31:0] ad, input logic [31:0] dt);
    item_t it;
    it.write = w; it.addr = ad; it.wdata = dt;
    return it;
  endfunction

  initial begin
    logic rdy;
    logic [1:0] rsp;
    logic [31:0] rd;
    int len;
    logic [31:0] ad;
    drv(0, 1'b0, 2'b00, 1'b0, 32'h0); drv_wd(0, 32'h0);
    drv(1, 1'b0, 2'b00, 1'b0, 32'h0); drv_wd(1, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    // Reset state of both instances.
    for (int s = 0; s < 2; s++) begin
      smp(s, rdy, rsp, rd);
      chk("rst_ready", 32'(rdy), 32'h1);
      chk("rst_resp", 32'(rsp), 32'h0);
      chk("rst_rdata", rd, 32'h0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait single write then read.
    q.push_back(mk(1, 32'h10, 32'hDEADBEEF)); run_burst(0);
    q.push_back(mk(0, 32'h10, 32'h0));        run_burst(0);
    // INCR4 write then INCR4 read, back to back.
    for (int i = 0; i < 4; i++) q.push_back(mk(1, 32'h20 + 32'(4*i), 32'(i + 1)));
    for (int i = 0; i < 4; i++) q.push_back(mk(0, 32'h20 + 32'(4*i), 32'h0));
    run_burst(0);
    // Read-after-write bypass.
    q.push_back(mk(1, 32'h50, 32'hA5A5_A5A5)); q.push_back(mk(0, 32'h50, 32'h0)); run_burst(0);
    // Error responses leave memory untouched (no aliasing of 0x400 onto word 0).
    q.push_back(mk(1, 32'h0, 32'h1111_2222));  run_burst(0);
    q.push_back(mk(1, 32'h400, 32'hBAD0_0001)); run_burst(0);
    q.push_back(mk(1, 32'h2, 32'hBAD0_0002));   run_burst(0);
    q.push_back(mk(0, 32'h0, 32'h0));           run_burst(0);

    // Deselected and BUSY cycles with write-looking controls are ignored.
    drv(0, 1'b0, 2'b10, 1'b1, 32'h10); drv_wd(0, 32'hBAD0_0003);
    @(posedge clk); #1;
    drv(0, 1'b1, 2'b01, 1'b1, 32'h10);
    @(negedge clk); smp(0, rdy, rsp, rd);
    chk("nosel_ready", 32'(rdy), 32'h1); chk("nosel_resp", 32'(rsp), 32'h0);
    @(posedge clk); #1;
    drv(0, 1'b0, 2'b00, 1'b0, 32'h0);
    @(negedge clk); smp(0, rdy, rsp, rd);
    chk("busy_ready", 32'(rdy), 32'h1); chk("busy_resp", 32'(rsp), 32'h0);
    @(posedge clk); #1;
    q.push_back(mk(0, 32'h10, 32'h0)); run_burst(0);

    // Two-wait instance: write/read 0x40, bypass-style pair, error.
    q.push_back(mk(1, 32'h40, 32'hC0FF_EE00)); run_burst(1);
    q.push_back(mk(0, 32'h40, 32'h0));         run_burst(1);
    q.push_back(mk(1, 32'h50, 32'hA5A5_A5A5)); q.push_back(mk(0, 32'h50, 32'h0)); run_burst(1);
    q.push_back(mk(0, 32'h404, 32'h0));        run_burst(1);

    // Reset during WAIT of a write to 0x60 drops the write.
    q.push_back(mk(1, 32'h60, 32'h5555_0000)); run_burst(1);
    drv(1, 1'b1, 2'b10, 1'b1, 32'h60);
    @(posedge clk); #1;
    drv(1, 1'b0, 2'b00, 1'b0, 32'h0); drv_wd(1, 32'h1234);
    smp(1, rdy, rsp, rd);
    chk("wait_low", 32'(rdy), 32'h0);
    #2 rst = 1'b1;
    #1 smp(1, rdy, rsp, rd);
    chk("midrst_ready", 32'(rdy), 32'h1);
    chk("midrst_resp", 32'(rsp), 32'h0);
    chk("midrst_rdata", rd, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    q.push_back(mk(0, 32'h60, 32'h0)); run_burst(1);

    // Randomized bursts on both instances.
    for (int s = 0; s < 2; s++) begin
      for (int it = 0; it < 25; it++) begin
        if ($urandom_range(7) == 0) begin
          ad = ($urandom_range(1) == 0) ? (32'($urandom_range(255)) * 4 + 32'($urandom_range(3, 1)))
                                        : (($urandom | 32'h400) & ~32'h3);
          q.push_back(mk($urandom_range(1) == 1, ad, $urandom));
        end else begin
          len = $urandom_range(4, 1);
          for (int k = 0; k < len; k++) begin
            if (k > 0 && $urandom_range(2) == 0)
              q.push_back(mk(0, q[k-1].addr, 32'h0));
            else
              q.push_back(mk($urandom_range(1) == 1, 32'($urandom_range(63)) * 4, $urandom));
          end
        end
        run_burst(s);
      end
      // Read back the whole random window.
      for (int w = 0; w < 64; w++) q.push_back(mk(0, 32'(w) * 4, 32'h0));
      run_burst(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
